// File: rtl/writeback_queue.sv
// Write-back queue between the execute stage and the 16 x 8-bit register file.
// Optional forwarding of the youngest pending result when WBQ_FORWARD_EN is defined.
module writeback_queue #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       Reset,
  input  logic                       ResultValid,
  output logic                       ResultReady,
  input  logic [DATA_W-1:0]          ResultData,
  input  logic [ADDR_W-1:0]          ResultDest,
  input  logic                       WriteStall,
  output logic                       RegFileWrite,
  output logic [DATA_W-1:0]          Datain,
  output logic [ADDR_W-1:0]          Destin,
  output logic [$clog2(DEPTH+1)-1:0] Count,
  output logic                       Empty,
  output logic                       Full,
  input  logic [ADDR_W-1:0]          QuerySrc1,
  input  logic [ADDR_W-1:0]          QuerySrc2,
  output logic                       Pending1,
  output logic                       Pending2,
  output logic [DATA_W-1:0]          Fwd1Data,
  output logic [DATA_W-1:0]          Fwd2Data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [ADDR_W-1:0] dest_q [DEPTH];
  logic [ADDR_W-1:0] dest_d [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic push, pop, full, empty;
  logic [DEPTH-1:0] hit1, hit2;

  // Acceptance depends on registered occupancy only, so a full queue refuses
  // a push even in the cycle it pops.
  always_comb begin
    full  = (count_q == CNT_W'(DEPTH));
    empty = (count_q == '0);
    push  = ResultValid && !full;
    pop   = !empty && !WriteStall;
  end

  always_comb begin
    data_d   = data_q;
    dest_d   = dest_q;
    valid_d  = valid_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PTR_W'(1);
    end
    if (push) begin
      data_d[wr_ptr_q]  = ResultData;
      dest_d[wr_ptr_q]  = ResultDest;
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every flop samples the pre-edge values of its peers.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: payload storage is deliberately not reset; every reader is qualified
  // by valid_q or by the empty flag, so stale contents are never observed.
  always_ff @(posedge clk) begin
    data_q <= data_d;
    dest_q <= dest_d;
  end

  always_comb begin
    ResultReady  = !full;
    RegFileWrite = pop;
    Count        = count_q;
    Empty        = empty;
    Full         = full;
    Datain       = empty ? '0 : data_q[rd_ptr_q];
    Destin       = empty ? '0 : dest_q[rd_ptr_q];
  end

  always_comb begin
    hit1 = '0;
    hit2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit1[i] = valid_q[i] && (dest_q[i] == QuerySrc1);
      hit2[i] = valid_q[i] && (dest_q[i] == QuerySrc2);
    end
    Pending1 = |hit1;
    Pending2 = |hit2;
  end

`ifdef WBQ_FORWARD_EN
  // Walk oldest to youngest so the last match (closest to the write pointer) wins.
  function automatic logic [DATA_W-1:0] youngest_match(input logic [DEPTH-1:0] hit);
    logic [DATA_W-1:0] val;
    logic [PTR_W-1:0]  idx;
    val = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_q + PTR_W'(k);
      if (hit[idx]) val = data_q[idx];
    end
    return val;
  endfunction

  always_comb begin
    Fwd1Data = youngest_match(hit1);
    Fwd2Data = youngest_match(hit2);
  end
`else
  always_comb begin
    Fwd1Data = '0;
    Fwd2Data = '0;
  end
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// Scoreboard bench for writeback_queue: stimulus pushes expected writes,
// a negedge monitor pops and compares each register-file write.
module tb_writeback_queue;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH+1);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] dest;
  } wb_t;

  logic              clk;
  logic              Reset;
  logic              ResultValid;
  logic              ResultReady;
  logic [DATA_W-1:0] ResultData;
  logic [ADDR_W-1:0] ResultDest;
  logic              WriteStall;
  logic              RegFileWrite;
  logic [DATA_W-1:0] Datain;
  logic [ADDR_W-1:0] Destin;
  logic [CNT_W-1:0]  Count;
  logic              Empty;
  logic              Full;
  logic [ADDR_W-1:0] QuerySrc1;
  logic [ADDR_W-1:0] QuerySrc2;
  logic              Pending1;
  logic              Pending2;
  logic [DATA_W-1:0] Fwd1Data;
  logic [DATA_W-1:0] Fwd2Data;

  wb_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  n_writes = 0;

`ifdef WBQ_FORWARD_EN
  localparam logic [DATA_W-1:0] FWD_66 = 8'h66;
`else
  localparam logic [DATA_W-1:0] FWD_66 = 8'h00;
`endif

  writeback_queue #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .Reset(Reset),
    .ResultValid(ResultValid), .ResultReady(ResultReady),
    .ResultData(ResultData), .ResultDest(ResultDest),
    .WriteStall(WriteStall), .RegFileWrite(RegFileWrite),
    .Datain(Datain), .Destin(Destin),
    .Count(Count), .Empty(Empty), .Full(Full),
    .QuerySrc1(QuerySrc1), .QuerySrc2(QuerySrc2),
    .Pending1(Pending1), .Pending2(Pending2),
    .Fwd1Data(Fwd1Data), .Fwd2Data(Fwd2Data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (Reset && RegFileWrite) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got dest %0h data %0h expected no write", Destin, Datain);
      end else begin
        wb_t e;
        e = exp_q.pop_front();
        check("wb_data", 32'(Datain), 32'(e.data));
        check("wb_dest", 32'(Destin), 32'(e.dest));
        n_writes++;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Offer one result, wait (bounded) for acceptance, record the expected write.
  task automatic offer(input logic [DATA_W-1:0] d, input logic [ADDR_W-1:0] r);
    int n;
    wb_t e;
    ResultValid = 1'b1;
    ResultData  = d;
    ResultDest  = r;
    n = 0;
    while (!ResultReady && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("offer_ready", 32'(ResultReady), 32'd1);
    @(posedge clk);
    #1;
    e.data = d;
    e.dest = r;
    exp_q.push_back(e);
    ResultValid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (!Empty && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", 32'(Empty), 32'd1);
    cyc();
  endtask

  initial begin
    int w0;
    Reset       = 1'b0;
    ResultValid = 1'b0;
    ResultData  = '0;
    ResultDest  = '0;
    WriteStall  = 1'b0;
    QuerySrc1   = 4'd3;
    QuerySrc2   = 4'd0;

    // Reset values
    #12;
    check("rst_count", 32'(Count), 32'd0);
    check("rst_empty", 32'(Empty), 32'd1);
    check("rst_full", 32'(Full), 32'd0);
    check("rst_ready", 32'(ResultReady), 32'd1);
    check("rst_write", 32'(RegFileWrite), 32'd0);
    check("rst_datain", 32'(Datain), 32'd0);
    check("rst_destin", 32'(Destin), 32'd0);
    check("rst_pend", 32'({Pending1, Pending2}), 32'd0);
    check("rst_fwd", 32'({Fwd1Data, Fwd2Data}), 32'd0);
    #1 Reset = 1'b1;
    cyc();

    // Single push: no bypass, write one cycle later for exactly one cycle
    ResultValid = 1'b1;
    ResultData  = 8'hAA;
    ResultDest  = 4'd3;
    #2;
    check("no_bypass", 32'(RegFileWrite), 32'd0);
    offer(8'hAA, 4'd3);
    check("t1_write", 32'(RegFileWrite), 32'd1);
    check("t1_destin", 32'(Destin), 32'd3);
    check("t1_datain", 32'(Datain), 32'hAA);
    check("t1_count", 32'(Count), 32'd1);
    check("t1_pend_head", 32'(Pending1), 32'd1);
    cyc();
    check("t1_write_off", 32'(RegFileWrite), 32'd0);
    check("t1_empty", 32'(Empty), 32'd1);
    check("t1_count0", 32'(Count), 32'd0);
    check("t1_datain0", 32'(Datain), 32'd0);

    // Fill under stall, fifth offer held, then in-order drain
    WriteStall = 1'b1;
    offer(8'h11, 4'd1);
    offer(8'h22, 4'd2);
    offer(8'h33, 4'd3);
    offer(8'h44, 4'd4);
    check("t2_full", 32'(Full), 32'd1);
    check("t2_ready", 32'(ResultReady), 32'd0);
    check("t2_count", 32'(Count), 32'd4);
    ResultValid = 1'b1;
    ResultData  = 8'h55;
    ResultDest  = 4'd5;
    cyc();
    cyc();
    check("t2_held_count", 32'(Count), 32'd4);
    check("t2_stall_nowrite", 32'(RegFileWrite), 32'd0);
    check("t2_stall_destin", 32'(Destin), 32'd1);
    WriteStall = 1'b0;
    offer(8'h55, 4'd5);
    drain();

    // Simultaneous push and pop at Count=2
    WriteStall = 1'b1;
    offer(8'hA1, 4'd1);
    offer(8'hA2, 4'd2);
    check("t3_count2", 32'(Count), 32'd2);
    WriteStall = 1'b0;
    offer(8'hA3, 4'd3);
    check("t3_count_same", 32'(Count), 32'd2);
    check("t3_head", 32'(Datain), 32'hA2);
    drain();

    // Duplicate destinations, pending and forwarding
    WriteStall = 1'b1;
    offer(8'h55, 4'd7);
    offer(8'h66, 4'd7);
    QuerySrc1 = 4'd7;
    QuerySrc2 = 4'd5;
    #1;
    check("t4_pend1", 32'(Pending1), 32'd1);
    check("t4_fwd1", 32'(Fwd1Data), 32'(FWD_66));
    check("t4_pend2", 32'(Pending2), 32'd0);
    check("t4_fwd2", 32'(Fwd2Data), 32'd0);
    WriteStall = 1'b0;
    #1;
    check("t4_pop_pend", 32'(Pending1), 32'd1);
    cyc();
    check("t4_last_pend", 32'(Pending1), 32'd1);
    check("t4_last_fwd", 32'(Fwd1Data), 32'(FWD_66));
    cyc();
    check("t4_done_pend", 32'(Pending1), 32'd0);
    check("t4_done_fwd", 32'(Fwd1Data), 32'd0);

    // Asynchronous reset mid-operation discards queued entries
    WriteStall = 1'b1;
    offer(8'hC1, 4'd1);
    offer(8'hC2, 4'd2);
    offer(8'hC3, 4'd3);
    WriteStall = 1'b0;
    #1;
    check("t5_pre_write", 32'(RegFileWrite), 32'd1);
    #1 Reset = 1'b0;
    #1;
    check("t5_write", 32'(RegFileWrite), 32'd0);
    check("t5_count", 32'(Count), 32'd0);
    check("t5_ready", 32'(ResultReady), 32'd1);
    check("t5_pend", 32'(Pending1), 32'd0);
    exp_q.delete();
    #20 Reset = 1'b1;
    repeat (5) cyc();
    check("t5_after_count", 32'(Count), 32'd0);

    // Back-to-back stream across pointer wrap
    w0 = n_writes;
    for (int i = 0; i < 10; i++) begin
      offer(DATA_W'(i + 1), ADDR_W'(i));
      check("t6_count_le1", 32'(Count <= 1), 32'd1);
    end
    drain();
    check("t6_writes", 32'(n_writes - w0), 32'd10);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
